// File: rtl/shifter_defs.sv
// shifter_defs: shared op and FSM state encodings for the iterative shifter.
package shifter_defs;
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational shift of data by 0..MAX_STEP bits, built as a log-stage mux chain.
module shift_step
    import shifter_defs::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int MAX_STEP = 4,
    localparam int SW       = $clog2(MAX_STEP) + 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    input  logic [SW-1:0]    step,
    output logic [WIDTH-1:0] result
);
    logic [SW:0][WIDTH-1:0] stg;
    assign stg[0] = data;
    for (genvar i = 0; i < SW; i++) begin : g_stage
        localparam int A = 1 << i;
        logic [WIDTH-1:0] sra, sh;
        // kept separate so the ternary below cannot strip the signedness of >>>
        assign sra = $signed(stg[i]) >>> A;
        always_comb begin
            sh = op == OP_SLL ? stg[i] << A :
                 op == OP_SRL ? stg[i] >> A :
                 op == OP_SRA ? sra : (stg[i] >> A) | (stg[i] << (WIDTH - A));
        end
        assign stg[i+1] = step[i] ? sh : stg[i];
    end
    assign result = stg[SW];
endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle SLL/SRL/SRA/ROR unit consuming up to MAX_STEP bits of shift per clock,
// with a start/busy/done handshake.
module iter_shifter
    import shifter_defs::*;
#(
    parameter int WIDTH    = 32,
    parameter int SHAMT_W  = 5,
    parameter int MAX_STEP = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   out,
    output logic               busy,
    output logic               done
);
    localparam int SW = $clog2(MAX_STEP) + 1;
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d, stepped;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [1:0]         op_q, op_d;
    logic [SW-1:0]      step;
    logic               busy_q, done_q, accept;
    assign step   = rem_q >= SHAMT_W'(MAX_STEP) ? SW'(MAX_STEP) : rem_q[SW-1:0];
    assign accept = start && state_q != ST_SHIFT;
    shift_step #(.WIDTH(WIDTH), .MAX_STEP(MAX_STEP)) u_step (
        .data  (out_q),
        .op    (op_q),
        .step  (step),
        .result(stepped)
    );
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        rem_d   = rem_q;
        op_d    = op_q;
        if (accept) begin
            out_d   = in;
            op_d    = op;
            rem_d   = shamt;
            state_d = shamt != '0 ? ST_SHIFT : ST_DONE;
        end else if (state_q == ST_SHIFT) begin
            out_d   = stepped;
            rem_d   = rem_q - SHAMT_W'(step);
            state_d = rem_d == '0 ? ST_DONE : ST_SHIFT;
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            busy_q  <= state_d == ST_SHIFT;
            done_q  <= state_d == ST_DONE;
        end
    end
    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
Multi-cycle, parametrised shift unit for the processor's shift operations: logical left, logical right, arithmetic right and rotate right. It generalises the single fixed arithmetic-right-by-4 stage to any width. It shifts the operand by up to MAX_STEP bits per clock until the full shift amount is consumed. It sits beside the ALU and the multdiv unit, and uses a start/busy/done handshake so the pipeline can stall on it.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2).
SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).
MAX_STEP, 4, maximum bits shifted per cycle; power of two, 1 <= MAX_STEP <= WIDTH/2.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled on a rising edge when accept condition holds.
op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
in  input  WIDTH  operand, captured with start.
shamt  input  SHAMT_W  shift amount, 0..WIDTH-1, captured with start.
out  output  WIDTH  result register.
busy  output  1  high while in SHIFT state.
done  output  1  one-cycle pulse: out holds final result.

Behaviour:
- Reset (async, active-high): state=IDLE, out=0, remaining=0, op_q=0, busy=0, done=0. Asserting reset mid-operation aborts immediately; no done pulse for the aborted request.
- States: IDLE, SHIFT, DONE.
- Accept condition: start=1 and state is IDLE or DONE (back-to-back allowed). start while in SHIFT is ignored, not queued.
- On accept edge: out<=in, op_q<=op, remaining<=shamt. Next state is SHIFT if shamt!=0, else DONE.
- SHIFT, each edge: step = MAX_STEP if remaining>=MAX_STEP, else remaining.
  - out <= shift(out, op_q, step); remaining <= remaining-step.
  - Go to DONE when remaining-step==0, else stay in SHIFT.
- DONE: done=1 for exactly this cycle. Next edge goes to IDLE, or accepts a new start.
- Latency: accept edge to done-high cycle = ceil(shamt/MAX_STEP)+1 cycles. shamt=0 gives 1 cycle.
- Step semantics, for step s in 0..MAX_STEP:
  - SLL: zero-fill from bit 0.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the current MSB of out. Sign is preserved across steps, so a multi-step SRA equals a single-shot SRA.
  - ROR: bits leaving bit 0 enter at bit WIDTH-1.
  - s=0 passes out unchanged.
- out is stable from the done cycle until the next accept edge. It is updated every SHIFT cycle; intermediate values are not meaningful.
- busy = (state==SHIFT). done = (state==DONE). Both are pure state decodes, glitch-free registered state.
- The shamt range is inherently 0..WIDTH-1. No overflow handling needed.
- in, op and shamt may change freely after the accept edge; only the captured copies are used.

Decomposition:
- Shared package/header shifter_defs: op encodings (OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11) and state encodings (ST_IDLE, ST_SHIFT, ST_DONE).
- One sub-module, shift_step: combinational, parametrised by WIDTH and MAX_STEP.
  - Inputs: data, op, step amount (width log2(MAX_STEP)+1).
  - Output: shifted data.
  - Built as a log-stage mux chain, the parametrised generalisation of the fixed by-4 stage.
- The top level holds the FSM, remaining counter and out register.

Test Plan:
- SRA, in=0x80000000, shamt=4 -> 1 SHIFT cycle; done 2 cycles after accept; out=0xF8000000; busy high exactly 1 cycle.
- SRA, in=0x80000000, shamt=31 -> 8 SHIFT cycles; done on cycle 9; out=0xFFFFFFFF. SRA in=0x7FFFFFFF, shamt=31 -> out=0x00000000.
- SRL in=0x80000000, shamt=7 -> steps 4 then 3, out=0x01000000. SLL in=0x00000001, shamt=0 -> done 1 cycle after accept, out=0x00000001, busy never high.
- ROR in=0x0000000F, shamt=4 -> out=0xF0000000. ROR in=0x12345678, shamt=8 -> out=0x78123456.
- Handshake:
  - start held high during SHIFT with different in -> ignored; result matches the first request.
  - start asserted in the DONE cycle -> accepted; second result correct.
  - Single done pulse per request.
- Reset: assert reset asynchronously mid-SHIFT (SRA 0x80000000 by 31, after 3 cycles) -> out=0, busy=0, done=0 immediately without a clock; no later done; the next request behaves normally.
- Sweep: for MAX_STEP in {1,2,4,8}, random in/op/shamt -> out matches the single-shot reference model; latency = ceil(shamt/MAX_STEP)+1.
